// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

  localparam logic [ADDR_W-1:0] PC_INCR = 64'd4;

  typedef enum logic {
    WAIT,
    STALL
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO of fetched {pc, instr} pairs; entry0 is always the head so
// the outputs come straight from registers.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         valid
);

  fetch_entry_t entry0;
  fetch_entry_t entry1;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_entry;
          else               entry1 <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count == 2'd1) begin
            entry0 <= push_entry;
          end else begin
            entry0 <= entry1;
            entry1 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = entry0;
  assign valid = (count != 2'd0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, read-wait timer and capture FSM driving instruction memory.
//   state | meaning
//   WAIT  | Address presented, timer counting down to the capture edge
//   STALL | word ready but queue full; Address and timer held until room
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          RD_WAIT  = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] Address,
  input  logic [31:0] Data,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [63:0] BranchTarget
);

  localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] pc, pc_next;
  logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;

  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic [1:0]   q_count;
  logic         q_valid;
  logic         pop;
  logic         push;
  logic         push_ok;
  logic         capture;

  assign pop        = q_valid && InstrReady;
  assign push_entry = '{pc: pc, instr: Data};

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    wait_cnt_next = wait_cnt;
    capture       = (state == STALL) || (wait_cnt == '0);
    push_ok       = (q_count < 2'd2) || pop;
    push          = capture && push_ok && !BranchTaken;

    if (BranchTaken) begin
      pc_next       = BranchTarget & ~64'd3;
      wait_cnt_next = WAIT_RELOAD;
      state_next    = WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt_next = wait_cnt - CNT_ONE;
          end else if (push_ok) begin
            pc_next       = pc + PC_INCR;
            wait_cnt_next = WAIT_RELOAD;
          end else begin
            state_next = STALL;
          end
        end
        STALL: begin
          if (push_ok) begin
            pc_next       = pc + PC_INCR;
            wait_cnt_next = WAIT_RELOAD;
            state_next    = WAIT;
          end
        end
        default: state_next = WAIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state    <= WAIT;
      pc       <= RESET_PC;
      wait_cnt <= WAIT_RELOAD;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // A redirect flushes the queue and suppresses any push or pop that cycle.
  fetch_queue u_queue (
    .clk        (CLK),
    .reset      (Reset),
    .push       (push),
    .pop        (pop),
    .flush      (BranchTaken),
    .push_entry (push_entry),
    .head       (head),
    .count      (q_count),
    .valid      (q_valid)
  );

  assign Address    = pc;
  assign Instr      = head.instr;
  assign InstrPC    = head.pc;
  assign InstrValid = q_valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: RD_WAIT=2 and RD_WAIT=1 instances share
// stimulus; a per-cycle model plus directed literal checks.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic        InstrReady;
  logic        BranchTaken;
  logic [63:0] BranchTarget;

  logic [63:0] addr_o  [2];
  logic [31:0] data_i  [2];
  logic [31:0] instr_o [2];
  logic [63:0] ipc_o   [2];
  logic        valid_o [2];

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  bit watch_cb = 0;
  bit seen_cb = 0;

  function automatic logic [31:0] mem(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF840_03E9;
      64'h4:   return 32'hF840_83EA;
      64'h8:   return 32'hCB09_018C;
      default: return a[31:0] ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign data_i[0] = mem(addr_o[0]);
  assign data_i[1] = mem(addr_o[1]);

  instruction_fetch_unit #(.RESET_PC(64'h0), .RD_WAIT(2)) u_dut2 (
    .CLK(CLK), .Reset(Reset), .Address(addr_o[0]), .Data(data_i[0]),
    .Instr(instr_o[0]), .InstrPC(ipc_o[0]), .InstrValid(valid_o[0]),
    .InstrReady(InstrReady), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget)
  );

  instruction_fetch_unit #(.RESET_PC(64'h0), .RD_WAIT(1)) u_dut1 (
    .CLK(CLK), .Reset(Reset), .Address(addr_o[1]), .Data(data_i[1]),
    .Instr(instr_o[1]), .InstrPC(ipc_o[1]), .InstrValid(valid_o[1]),
    .InstrReady(InstrReady), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Model: an address must have been presented for rd_wait cycles before its
  // word is ready; a ready word enters the queue when there is room.
  logic [63:0] m_addr [2];
  int          m_held [2];
  int          m_n    [2];
  logic [63:0] m_pc   [2][2];
  logic [31:0] m_ins  [2][2];

  always @(posedge CLK) begin
    for (int i = 0; i < 2; i++) begin
      int  rdw;
      bit  popped;
      bit  room;
      rdw = (i == 0) ? 2 : 1;
      if (Reset) begin
        m_addr[i] = 64'h0;
        m_held[i] = 0;
        m_n[i]    = 0;
      end else if (BranchTaken) begin
        m_addr[i] = {BranchTarget[63:2], 2'b00};
        m_held[i] = 0;
        m_n[i]    = 0;
      end else begin
        popped = (m_n[i] > 0) && InstrReady;
        room   = (m_n[i] < 2) || popped;
        if (popped) begin
          m_pc[i][0]  = m_pc[i][1];
          m_ins[i][0] = m_ins[i][1];
          m_n[i]      = m_n[i] - 1;
        end
        if (m_held[i] >= rdw - 1 && room) begin
          m_pc[i][m_n[i]]  = m_addr[i];
          m_ins[i][m_n[i]] = mem(m_addr[i]);
          m_n[i]           = m_n[i] + 1;
          m_addr[i]        = m_addr[i] + 64'd4;
          m_held[i]        = 0;
        end else begin
          m_held[i] = m_held[i] + 1;
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("model addr[%0d]", i), addr_o[i], m_addr[i]);
        chk($sformatf("model valid[%0d]", i), 64'(valid_o[i]), 64'(m_n[i] > 0));
        if (m_n[i] > 0) begin
          chk($sformatf("model instr[%0d]", i), 64'(instr_o[i]), 64'(m_ins[i][0]));
          chk($sformatf("model pc[%0d]", i), ipc_o[i], m_pc[i][0]);
        end
      end
      if (watch_cb && valid_o[0] && instr_o[0] == 32'hCB09_018C) seen_cb = 1;
    end
  end

  initial begin
    logic [63:0] exp_seq [4];
    logic [31:0] pat;
    exp_seq = '{64'h0, 64'h4, 64'h4, 64'h8};
    Reset = 1; InstrReady = 1; BranchTaken = 0; BranchTarget = 64'h0;
    tick(1);
    chk_en = 1;
    tick(1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset addr[%0d]", i), addr_o[i], 64'h0);
      chk($sformatf("reset valid[%0d]", i), 64'(valid_o[i]), 64'h0);
      chk($sformatf("reset instr[%0d]", i), 64'(instr_o[i]), 64'h0);
      chk($sformatf("reset pc[%0d]", i), ipc_o[i], 64'h0);
    end

    // Sequential fetch
    Reset = 0;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk($sformatf("seq addr e%0d", k + 1), addr_o[0], exp_seq[k]);
      if (k == 0) chk("first valid early", 64'(valid_o[0]), 64'h0);
      if (k == 1) begin
        chk("first valid", 64'(valid_o[0]), 64'h1);
        chk("first instr", 64'(instr_o[0]), 64'hF840_03E9);
        chk("first pc", ipc_o[0], 64'h0);
      end
      if (k == 3) begin
        chk("second instr", 64'(instr_o[0]), 64'hF840_83EA);
        chk("second pc", ipc_o[0], 64'h4);
      end
    end

    // Backpressure, then redirect while full
    Reset = 1;
    tick(1);
    Reset = 0; InstrReady = 0; watch_cb = 1;
    tick(6);
    chk("bp addr held", addr_o[0], 64'h8);
    chk("bp head pc", ipc_o[0], 64'h0);
    InstrReady = 1;
    tick(1);
    chk("bp pop+push pc", ipc_o[0], 64'h4);
    chk("bp pop+push addr", addr_o[0], 64'hC);
    InstrReady = 0;
    tick(2);
    BranchTaken = 1; BranchTarget = 64'h1C;
    tick(1);
    BranchTaken = 0;
    chk("redir addr", addr_o[0], 64'h1C);
    chk("redir valid", 64'(valid_o[0]), 64'h0);
    InstrReady = 1;
    tick(2);
    chk("redir first valid", 64'(valid_o[0]), 64'h1);
    chk("redir first pc", ipc_o[0], 64'h1C);
    chk("flushed word never head", 64'(seen_cb), 64'h0);
    watch_cb = 0;

    // Redirect on a capture edge with a pop, unaligned target
    tick(2);
    chk("pre-coincident pc", ipc_o[0], 64'h20);
    InstrReady = 0;
    tick(1);
    InstrReady = 1; BranchTaken = 1; BranchTarget = 64'h1F;
    tick(1);
    BranchTaken = 0;
    chk("coincident addr", addr_o[0], 64'h1C);
    chk("coincident valid", 64'(valid_o[0]), 64'h0);

    // Reset while stalled with a full queue
    InstrReady = 0;
    tick(7);
    chk("stall head pc", ipc_o[0], 64'h1C);
    Reset = 1;
    tick(1);
    Reset = 0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset addr[%0d]", i), addr_o[i], 64'h0);
      chk($sformatf("midreset valid[%0d]", i), 64'(valid_o[i]), 64'h0);
      chk($sformatf("midreset instr[%0d]", i), 64'(instr_o[i]), 64'h0);
      chk($sformatf("midreset pc[%0d]", i), ipc_o[i], 64'h0);
    end

    // Wrap and single-cycle throughput on the RD_WAIT=1 instance
    InstrReady = 1; BranchTaken = 1; BranchTarget = 64'hFFFF_FFFF_FFFF_FFFC;
    tick(1);
    BranchTaken = 0;
    chk("wrap addr", addr_o[1], 64'hFFFF_FFFF_FFFF_FFFC);
    tick(1);
    chk("wrap pc0", ipc_o[1], 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap addr0", addr_o[1], 64'h0);
    tick(1);
    chk("wrap pc1", ipc_o[1], 64'h0);
    tick(1);
    chk("wrap pc2", ipc_o[1], 64'h4);

    // Mixed ready pattern with a mid-stream redirect
    pat = 32'hB5D3_4C9A;
    for (int k = 0; k < 48; k++) begin
      InstrReady   = pat[k % 32];
      BranchTaken  = (k == 20);
      BranchTarget = 64'h40;
      tick(1);
    end
    BranchTaken = 0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
